// File: rtl/serial_pkg.sv
// serial_pkg: shared types and helpers for the UART transmitter/receiver pair
package serial_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} rx_state_t;

    function automatic int clks_per_bit(input int freq, input int baud);
        return (freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for an asynchronous single-bit input
//   clock   in  system clock
//   reset_n in  asynchronous active-low reset, loads RESET_VALUE into both flops
//   d       in  asynchronous input
//   q       out synchronised output (2 cycles of latency)
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/serial_receiver.sv
// serial_receiver: UART 8N1 receiver with valid/ready byte output
//   clock             in  system clock
//   reset_n           in  asynchronous active-low reset
//   serial_rx         in  raw asynchronous UART line, idle high
//   rx_data           out last received byte
//   rx_data_available out rx_data holds an unconsumed byte
//   rx_ready          in  consumer takes rx_data when high with rx_data_available
//   framing_error     out one-cycle pulse, stop bit sampled low
//   overrun           out one-cycle pulse, new byte replaced an unconsumed one
module serial_receiver
    import serial_pkg::*;
#(
    parameter int CLOCK_FREQ_HZ = 48_000_000,
    parameter int BAUD_RATE     = 115_200
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 serial_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_data_available,
    input  logic                 rx_ready,
    output logic                 framing_error,
    output logic                 overrun
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ_HZ, BAUD_RATE);
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam int BW           = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    if (CLKS_PER_BIT < 4) begin : g_bad_rate
        $error("serial_receiver: CLKS_PER_BIT must be at least 4");
    end

    logic                 rx_s;
    rx_state_t            state;
    logic [CW-1:0]        clk_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 deliver;

    sync_2ff #(.RESET_VALUE(1'b1)) u_sync (
        .clock  (clock),
        .reset_n(reset_n),
        .d      (serial_rx),
        .q      (rx_s)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            clk_cnt           <= '0;
            bit_cnt           <= '0;
            shift             <= '0;
            deliver           <= 1'b0;
            rx_data           <= '0;
            rx_data_available <= 1'b0;
            framing_error     <= 1'b0;
            overrun           <= 1'b0;
        end else begin
            framing_error <= 1'b0;
            overrun       <= 1'b0;
            deliver       <= 1'b0;
            // A same-cycle rx_ready consumes the old byte, so only an unread one overruns.
            if (deliver) begin
                rx_data           <= shift;
                rx_data_available <= 1'b1;
                overrun           <= rx_data_available && !rx_ready;
            end else if (rx_data_available && rx_ready) begin
                rx_data_available <= 1'b0;
            end
            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    state   <= rx_s ? IDLE : START;
                end
                START: begin
                    clk_cnt <= (clk_cnt == HALF_LAST) ? '0 : clk_cnt + 1'b1;
                    bit_cnt <= '0;
                    if (clk_cnt == HALF_LAST) state <= rx_s ? IDLE : DATA;
                end
                DATA: begin
                    clk_cnt <= (clk_cnt == BIT_LAST) ? '0 : clk_cnt + 1'b1;
                    if (clk_cnt == BIT_LAST) begin
                        shift   <= {rx_s, shift[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) state <= STOP;
                    end
                end
                STOP: begin
                    clk_cnt <= (clk_cnt == BIT_LAST) ? '0 : clk_cnt + 1'b1;
                    // Leaving at mid-stop lets a back-to-back start bit be caught.
                    if (clk_cnt == BIT_LAST) begin
                        deliver       <= rx_s;
                        framing_error <= !rx_s;
                        state         <= rx_s ? IDLE : WAIT_IDLE;
                    end
                end
                WAIT_IDLE: state <= rx_s ? IDLE : WAIT_IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_receiver.sv
// tb_serial_receiver: directed and random UART frames against a byte-queue reference
module tb_serial_receiver;

    localparam int CPB = 16;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       serial_rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_data_available;
    logic       framing_error;
    logic       overrun;

    serial_receiver #(
        .CLOCK_FREQ_HZ(1_600_000),
        .BAUD_RATE    (100_000)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .serial_rx        (serial_rx),
        .rx_data          (rx_data),
        .rx_data_available(rx_data_available),
        .rx_ready         (rx_ready),
        .framing_error    (framing_error),
        .overrun          (overrun)
    );

    always #5 clock = ~clock;

    int passed = 0;
    int total = 0;
    int cyc = 0;
    int fall_cyc = 0;
    int rise_cyc = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int av_cycles = 0;
    logic av_d = 1'b0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];

    // Observes delivered bytes and event pulses away from the active edge.
    always @(negedge clock) begin
        if (rx_data_available && !av_d) begin
            got.push_back(rx_data);
            rise_cyc = cyc;
        end
        av_d = rx_data_available;
        if (rx_data_available) av_cycles++;
        if (framing_error) fe_cnt++;
        if (overrun) ov_cnt++;
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic clr();
        got.delete();
        exp_q.delete();
        fe_cnt = 0;
        ov_cnt = 0;
        av_cycles = 0;
    endtask

    task automatic line(input logic v, input int n);
        serial_rx = v;
        repeat (n) @(negedge clock);
    endtask

    task automatic frame(input logic [7:0] b, input logic stop);
        fall_cyc = cyc;
        line(1'b0, CPB);
        for (int i = 0; i < 8; i++) line(b[i], CPB);
        line(stop, CPB);
    endtask

    function automatic logic [7:0] got0();
        return (got.size() > 0) ? got[0] : 8'hxx;
    endfunction

    initial begin
        logic [7:0] b;
        int lat;
        repeat (3) @(negedge clock);
        chk("reset_data", {24'h0, rx_data}, 32'h00);
        chk("reset_avail", {31'h0, rx_data_available}, 32'h0);
        chk("reset_fe", {31'h0, framing_error}, 32'h0);
        chk("reset_ov", {31'h0, overrun}, 32'h0);
        reset_n = 1'b1;
        line(1'b1, 4 * CPB);

        // single frame with ready held high
        rx_ready = 1'b1;
        clr();
        frame(8'h55, 1'b1);
        line(1'b1, 3 * CPB);
        lat = rise_cyc - fall_cyc;
        chk("t1_count", got.size(), 1);
        chk("t1_data", {24'h0, got0()}, 32'h55);
        chk("t1_avail_cycles", av_cycles, 1);
        chk("t1_latency_window", {31'h0, (lat >= 154 && lat <= 158)}, 32'h1);
        chk("t1_errors", fe_cnt + ov_cnt, 0);

        // back-to-back frames, nothing consumed
        rx_ready = 1'b0;
        clr();
        frame(8'hA3, 1'b1);
        frame(8'h0F, 1'b1);
        line(1'b1, 2 * CPB);
        chk("t2_first_byte", {24'h0, got0()}, 32'hA3);
        chk("t2_overrun_pulses", ov_cnt, 1);
        chk("t2_data", {24'h0, rx_data}, 32'h0F);
        chk("t2_avail", {31'h0, rx_data_available}, 32'h1);
        rx_ready = 1'b1;
        @(negedge clock);
        chk("t2_consumed", {31'h0, rx_data_available}, 32'h0);

        // short low glitch is rejected, next frame still received
        clr();
        line(1'b0, 4);
        line(1'b1, 3 * CPB);
        chk("t3_no_data", got.size(), 0);
        chk("t3_no_fe", fe_cnt, 0);
        b = 8'($urandom);
        frame(b, 1'b1);
        line(1'b1, 2 * CPB);
        chk("t3_after_glitch", {24'h0, got0()}, {24'h0, b});

        // framing error then recovery
        clr();
        frame(8'hC6, 1'b0);
        line(1'b1, 3 * CPB);
        chk("t4_fe_pulses", fe_cnt, 1);
        chk("t4_no_data", got.size(), 0);
        chk("t4_avail", {31'h0, rx_data_available}, 32'h0);
        frame(8'h12, 1'b1);
        line(1'b1, 2 * CPB);
        chk("t4_recover", {24'h0, got0()}, 32'h12);

        // break condition
        clr();
        line(1'b0, 40 * CPB);
        chk("t5_fe_pulses", fe_cnt, 1);
        chk("t5_no_data", got.size(), 0);
        line(1'b1, 2 * CPB);
        chk("t5_still_none", got.size(), 0);
        rx_ready = 1'b0;
        b = 8'($urandom);
        frame(b, 1'b1);
        line(1'b1, 2 * CPB);
        chk("t5_after_break", {24'h0, got0()}, {24'h0, b});
        chk("t5_fe_total", fe_cnt, 1);

        // reset during bit 4; upper nibble high so the aborted remainder is idle-like
        clr();
        b = {4'hF, 4'($urandom)};
        line(1'b0, CPB);
        for (int i = 0; i < 4; i++) line(b[i], CPB);
        line(b[4], CPB / 2);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_data", {24'h0, rx_data}, 32'h00);
        chk("t6_rst_avail", {31'h0, rx_data_available}, 32'h0);
        chk("t6_rst_fe_ov", {30'h0, framing_error, overrun}, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        line(b[4], CPB / 2 - 1);
        for (int i = 5; i < 8; i++) line(b[i], CPB);
        line(1'b1, 3 * CPB);
        chk("t6_no_partial", got.size(), 0);
        rx_ready = 1'b1;
        frame(8'h7E, 1'b1);
        line(1'b1, 2 * CPB);
        chk("t6_next_frame", {24'h0, got0()}, 32'h7E);

        // random bytes with random idle gaps
        clr();
        for (int k = 0; k < 6; k++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            frame(b, 1'b1);
            line(1'b1, int'($urandom_range(0, 2)) * CPB);
        end
        line(1'b1, 2 * CPB);
        chk("rnd_count", got.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++)
            chk($sformatf("rnd_byte%0d", k), {24'h0, (k < got.size()) ? got[k] : 8'hxx}, {24'h0, exp_q[k]});
        chk("rnd_errors", fe_cnt + ov_cnt, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
